// File: rtl/poly_raster_pkg.sv
// Purpose : shared types, constants and helpers for the polygon span rasteriser.
// Contents: coord_t (screen coordinate), delta_t (edge delta), edge_t (edge
//           function value), state_t (control FSM), MAX_VERTS, span_base().
package poly_raster_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned DELTA_W   = 11;
    localparam int unsigned EDGE_W    = 32;
    localparam int unsigned MAX_VERTS = 8;

    typedef logic        [COORD_W-1:0] coord_t;
    typedef logic signed [DELTA_W-1:0] delta_t;
    typedef logic signed [EDGE_W-1:0]  edge_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Warp-aligned base containing x, clamped to the last warp on the scanline
    // so every job always has at least one beat to carry out_last.
    function automatic coord_t span_base(input coord_t x, input int unsigned warp,
                                         input int unsigned screen_w);
        int unsigned base;
        base = (32'(x) / warp) * warp;
        if (base > screen_w - warp) begin
            base = screen_w - warp;
        end
        return coord_t'(base);
    endfunction

endpackage

// File: rtl/poly_edge_step.sv
// Purpose : one polygon edge. Latches dY, the edge function at the sweep start
//           and the degenerate flag on load, advances by WARP_WIDTH*dY on step,
//           and produces the per-pixel "inside this edge" vector for the warp.
// Ports   : clk, rst_n (sync, active-low), load (SETUP cycle), step (beat
//           generated), x0/y0 start vertex, x1/y1 end vertex, draw_y scanline,
//           x_start first warp x, sign_vec[k]=1 when pixel x+k is inside.
module poly_edge_step
    import poly_raster_pkg::*;
#(
    parameter int unsigned WARP_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  coord_t                x0,
    input  coord_t                y0,
    input  coord_t                x1,
    input  coord_t                y1,
    input  coord_t                draw_y,
    input  coord_t                x_start,
    output logic [WARP_WIDTH-1:0] sign_vec
);

    localparam edge_t WARP_S = edge_t'(WARP_WIDTH);

    delta_t dx_c;
    delta_t dy_c;
    delta_t rel_x_c;
    delta_t rel_y_c;
    edge_t  e_start_c;
    logic   degen_c;

    delta_t dy_q;
    edge_t  e_base_q;
    logic   degen_q;

    edge_t  e_k;

    // Edge deltas and E(x_start, draw_y) from the captured job
    always_comb begin
        dx_c      = delta_t'({1'b0, x1}) - delta_t'({1'b0, x0});
        dy_c      = delta_t'({1'b0, y1}) - delta_t'({1'b0, y0});
        rel_x_c   = delta_t'({1'b0, x_start}) - delta_t'({1'b0, x0});
        rel_y_c   = delta_t'({1'b0, draw_y}) - delta_t'({1'b0, y0});
        e_start_c = edge_t'(rel_x_c) * edge_t'(dy_c) - edge_t'(rel_y_c) * edge_t'(dx_c);
        degen_c   = (dx_c == '0) && (dy_c == '0);
    end

    // Edge state: latched in SETUP, advanced one warp per generated beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dy_q     <= '0;
            e_base_q <= '0;
            degen_q  <= 1'b0;
        end else if (load) begin
            dy_q     <= dy_c;
            e_base_q <= e_start_c;
            degen_q  <= degen_c;
        end else if (step) begin
            e_base_q <= e_base_q + WARP_S * edge_t'(dy_q);
        end
    end

    // Strict inside test per pixel; a degenerate edge never excludes anything
    always_comb begin
        sign_vec = '0;
        e_k      = '0;
        for (int unsigned k = 0; k < WARP_WIDTH; k++) begin
            e_k         = e_base_q + edge_t'(k) * edge_t'(dy_q);
            sign_vec[k] = degen_q | e_k[EDGE_W-1];
        end
    end

endmodule

// File: rtl/poly_span_raster.sv
// Purpose : rasterise one scanline of a convex polygon into WARP_WIDTH-pixel
//           coverage masks, one beat per cycle with valid/ready backpressure.
// Ports   : clk, rst_n (sync, active-low); in_valid/in_ready job handshake with
//           vertices ([i][0]=x, [i][1]=y) and drawY; out_valid/out_ready beat
//           handshake carrying out_mask, out_xbase and out_last.
// Config  : POLY_RASTER_BBOX_SKIP_EN -- emit only warps overlapping the polygon's
//           x extent instead of the whole scanline.
module poly_span_raster
    import poly_raster_pkg::*;
#(
    parameter int unsigned WARP_WIDTH = 32,
    parameter int unsigned NUM_VERTS  = 4,
    parameter int unsigned SCREEN_W   = 640
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_VERTS-1:0][1:0][COORD_W-1:0] vertices,
    input  logic [COORD_W-1:0]                  drawY,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WARP_WIDTH-1:0]               out_mask,
    output logic [COORD_W-1:0]                  out_xbase,
    output logic                                out_last
);

    localparam coord_t XSTEP     = coord_t'(WARP_WIDTH);
    localparam coord_t LAST_WARP = coord_t'(SCREEN_W - WARP_WIDTH);

    state_t state;

    logic [NUM_VERTS-1:0][1:0][COORD_W-1:0] cap_verts;
    coord_t cap_y;
    coord_t x_cur;
    coord_t x_last;
    logic   pending;

    coord_t x_first_c;
    coord_t x_last_c;
    logic   setup_c;
    logic   adv_c;

    logic [NUM_VERTS-1:0][WARP_WIDTH-1:0] edge_vec;
    logic [WARP_WIDTH-1:0]                mask_c;

`ifdef POLY_RASTER_BBOX_SKIP_EN
    coord_t min_x;
    coord_t max_x;

    // Sweep range limited to warps overlapping [min X, max X]
    always_comb begin
        min_x = cap_verts[0][0];
        max_x = cap_verts[0][0];
        for (int unsigned i = 1; i < NUM_VERTS; i++) begin
            if (cap_verts[i][0] < min_x) begin
                min_x = cap_verts[i][0];
            end
            if (cap_verts[i][0] > max_x) begin
                max_x = cap_verts[i][0];
            end
        end
        x_first_c = span_base(min_x, WARP_WIDTH, SCREEN_W);
        x_last_c  = span_base(max_x, WARP_WIDTH, SCREEN_W);
    end
`else
    // Sweep covers the full scanline
    always_comb begin
        x_first_c = '0;
        x_last_c  = LAST_WARP;
    end
`endif

    // A new beat is generated whenever the output register is free or draining
    always_comb begin
        setup_c = (state == SETUP);
        adv_c   = (state == SWEEP) && pending && (!out_valid || out_ready);
    end

    for (genvar i = 0; i < NUM_VERTS; i++) begin : g_edge
        localparam int unsigned NXT = (i + 1) % NUM_VERTS;
        poly_edge_step #(
            .WARP_WIDTH (WARP_WIDTH)
        ) u_edge (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (setup_c),
            .step     (adv_c),
            .x0       (cap_verts[i][0]),
            .y0       (cap_verts[i][1]),
            .x1       (cap_verts[NXT][0]),
            .y1       (cap_verts[NXT][1]),
            .draw_y   (cap_y),
            .x_start  (x_first_c),
            .sign_vec (edge_vec[i])
        );
    end

    // Pixel is covered only when inside every edge
    always_comb begin
        mask_c = '1;
        for (int unsigned i = 0; i < NUM_VERTS; i++) begin
            mask_c &= edge_vec[i];
        end
    end

    // Control FSM and registered output beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            cap_verts <= '0;
            cap_y     <= '0;
            x_cur     <= '0;
            x_last    <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            out_mask  <= '0;
            out_xbase <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        cap_verts <= vertices;
                        cap_y     <= drawY;
                        in_ready  <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    x_cur   <= x_first_c;
                    x_last  <= x_last_c;
                    pending <= 1'b1;
                    state   <= SWEEP;
                end
                SWEEP: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else if (adv_c) begin
                        out_valid <= 1'b1;
                        out_mask  <= mask_c;
                        out_xbase <= x_cur;
                        out_last  <= (x_cur == x_last);
                        pending   <= (x_cur != x_last);
                        x_cur     <= x_cur + XSTEP;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/poly_span_raster.md
POLY_SPAN_RASTER -- requirements
Module: poly_span_raster

Interface
REQ-001 Parameter WARP_WIDTH, default 32, pixels tested per output beat; SCREEN_W % WARP_WIDTH SHALL be 0.
REQ-002 Parameter NUM_VERTS, default 4, polygon vertex count, legal range 3..8.
REQ-003 Parameter SCREEN_W, default 640, pixels per scanline.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  job request.
REQ-007 in_ready  out  1  high only in IDLE.
REQ-008 vertices  in  NUM_VERTS x 2 x 10  unsigned screen coordinates; [i][0]=x, [i][1]=y.
REQ-009 drawY  in  10  scanline to rasterise.
REQ-010 out_valid  out  1  beat valid.
REQ-011 out_ready  in  1  consumer accepts beat.
REQ-012 out_mask  out  WARP_WIDTH  bit k=1 iff pixel (out_xbase+k, drawY) is inside.
REQ-013 out_xbase  out  10  x of mask bit 0; always a multiple of WARP_WIDTH.
REQ-014 out_last  out  1  marks final beat of the job.

Function
REQ-015 Edge i runs from vertex i to vertex (i+1)%NUM_VERTS; dX_i, dY_i SHALL be signed 11-bit differences (end minus start).
REQ-016 E_i(x,y) = (x-X_i)*dY_i - (y-Y_i)*dX_i, signed 32-bit; pixel inside iff E_i<0 for every non-degenerate edge.
REQ-017 Edge with dX_i=dY_i=0 SHALL be degenerate and ignored, so repeated vertices yield a polygon with fewer vertices.
REQ-018 FSM states IDLE, SETUP, SWEEP; in_valid&&in_ready SHALL capture vertices/drawY and move IDLE->SETUP.
REQ-019 SETUP (1 cycle): register dX, dY, E_i(0,drawY), degenerate flags, x bounds; -> SWEEP.
REQ-020 First out_valid SHALL assert 2 cycles after the accepting edge; one beat per cycle thereafter while out_ready=1.
REQ-021 Mask bit k SHALL use E_base_i + k*dY_i; E_base_i SHALL advance by WARP_WIDTH*dY_i on each accepted beat; results SHALL equal REQ-016 exactly.
REQ-022 out_valid&&!out_ready SHALL hold out_mask, out_xbase, out_last stable.
REQ-023 Accepted beat with out_last=1 SHALL return FSM to IDLE; in_ready SHALL be 1 on the following cycle.
REQ-024 Inputs changing outside the accept cycle SHALL not affect a job in progress.

Reset
REQ-025 rst_n=0 at any clock edge, including mid-SWEEP, SHALL force IDLE, out_valid=0, out_last=0, out_mask=0, out_xbase=0, in_ready=1 next cycle; the job is discarded.

Configuration
REQ-026 Macro POLY_RASTER_BBOX_SKIP_EN defined: only beats whose span [xbase, xbase+WARP_WIDTH-1] intersects [min X_i, max X_i] SHALL be emitted, and out_last SHALL mark the last such beat.
REQ-027 Macro undefined: all SCREEN_W/WARP_WIDTH beats SHALL be emitted, xbase 0 upward, out_last on xbase = SCREEN_W-WARP_WIDTH.

Structure
REQ-028 Package poly_raster_pkg SHALL hold coord_t (10-bit), delta_t (signed 11), edge_t (signed 32), state enum, and MAX_VERTS=8.
REQ-029 Sub-module poly_edge_step SHALL hold one edge's registered dX/dY/E_base, degenerate flag and WARP_WIDTH-wide sign vector; NUM_VERTS instances, ANDed in the top level.

Verification (WARP_WIDTH=32, SCREEN_W=640, NUM_VERTS=4)
REQ-030 Square (50,50),(100,50),(100,100),(50,100), drawY=75, macro off -> 20 beats; xbase 32 bits 19..31 set, xbase 64 all set, xbase 96 bits 0..3 set, all others 0; out_last on xbase 608.
REQ-031 Same job, macro on -> 3 beats, xbase 32/64/96, same masks, out_last on xbase 96.
REQ-032 Same square, drawY=50 and drawY=100 -> all masks 0 (strict edges).
REQ-033 Triangle (50,50),(100,50),(100,100),(50,50), drawY=75 -> set pixels exactly x=76..99; degenerate edge 3 ignored.
REQ-034 Random out_ready deassertion during REQ-030 job -> held beats stable and the accepted sequence identical to REQ-030.
REQ-035 rst_n=0 for 1 cycle at beat 5 of REQ-030 job -> out_valid=0 next cycle, in_ready=1; a new job then produces the REQ-030 result.
